sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Merges the core's fetch and data ports onto one addr_ok/data_ok memory port.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_valid,
    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_valid,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sel_data;
    logic                  w_sel_nxt;

    logic                  r_inst_pend;
    logic [ADDR_W-1:0]     r_inst_addr;
    logic                  r_data_pend;
    logic [ADDR_W-1:0]     r_data_addr;
    logic [DATA_W/8-1:0]   r_data_wen;
    logic [DATA_W-1:0]     r_data_wdata;

    logic [DATA_W-1:0]     r_inst_rdata;
    logic [DATA_W-1:0]     r_data_rdata;
    logic                  r_inst_valid;
    logic                  r_data_valid;

    logic                  w_stall;
    logic                  w_inst_cap;
    logic                  w_data_cap;
    logic                  w_done;
    logic                  w_other_pend;
    logic                  w_in_addr;

    assign w_stall      = (r_state != ST_IDLE) || r_inst_pend || r_data_pend;
    assign w_inst_cap   = inst_req && !w_stall;
    assign w_data_cap   = data_req && !w_stall;
    assign w_done       = (r_state == ST_WAIT) && mem_data_ok;
    assign w_other_pend = r_sel_data ? r_inst_pend : r_data_pend;
    assign w_in_addr    = (r_state == ST_ADDR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sel_data <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel_data <= w_sel_nxt;
        end
    end

    // Source selection is latched on entry to ADDR and held through WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_data;
        case (r_state)
            ST_IDLE: begin
                if (w_inst_cap || w_data_cap) begin
                    w_state_nxt = ST_ADDR;
                    w_sel_nxt   = w_data_cap;
                end
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_data_ok) begin
                    if (w_other_pend) begin
                        w_state_nxt = ST_ADDR;
                        w_sel_nxt   = !r_sel_data;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_pend  <= 1'b0;
            r_inst_addr  <= '0;
            r_data_pend  <= 1'b0;
            r_data_addr  <= '0;
            r_data_wen   <= '0;
            r_data_wdata <= '0;
        end else begin
            if (w_inst_cap) begin
                r_inst_pend <= 1'b1;
                r_inst_addr <= inst_addr;
            end else if (w_done && !r_sel_data) begin
                r_inst_pend <= 1'b0;
            end
            if (w_data_cap) begin
                r_data_pend  <= 1'b1;
                r_data_addr  <= data_addr;
                r_data_wen   <= data_wen;
                r_data_wdata <= data_wdata;
            end else if (w_done && r_sel_data) begin
                r_data_pend <= 1'b0;
            end
        end
    end

    // Stores complete with a valid pulse but leave the load result untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_inst_valid <= w_done && !r_sel_data;
            r_data_valid <= w_done && r_sel_data;
            if (w_done && !r_sel_data) begin
                r_inst_rdata <= mem_rdata;
            end
            if (w_done && r_sel_data && (r_data_wen == '0)) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req    = w_in_addr;
    assign mem_addr   = !w_in_addr ? '0 : (r_sel_data ? r_data_addr : r_inst_addr);
    assign mem_wr     = w_in_addr && r_sel_data && (r_data_wen != '0);
    assign mem_wstrb  = (w_in_addr && r_sel_data) ? r_data_wen : '0;
    assign mem_wdata  = (w_in_addr && r_sel_data) ? r_data_wdata : '0;

    assign cpu_stall  = w_stall;
    assign inst_valid = r_inst_valid;
    assign data_valid = r_data_valid;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Directed bench with a transaction-level model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        s_addr_ok = 1'b0;
    logic        s_data_ok = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        f_addr_ok = 1'b0;
    logic        f_data_ok = 1'b0;
    assign mem_addr_ok = s_addr_ok | f_addr_ok;
    assign mem_data_ok = s_data_ok | f_data_ok;
    assign mem_rdata   = s_rdata;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_valid(data_valid), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } txn_t;

    txn_t        m_q[$];
    txn_t        m_tmp;
    logic        m_issued = 1'b0;
    logic        exp_ivalid = 1'b0;
    logic        exp_dvalid = 1'b0;
    logic [31:0] exp_irdata = '0;
    logic [31:0] exp_drdata = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_issued   = 1'b0;
            exp_ivalid = 1'b0;
            exp_dvalid = 1'b0;
            exp_irdata = '0;
            exp_drdata = '0;
        end else begin
            exp_ivalid = 1'b0;
            exp_dvalid = 1'b0;
            if (m_q.size() != 0) begin
                if (!m_issued) begin
                    if (mem_addr_ok) m_issued = 1'b1;
                end else if (mem_data_ok) begin
                    m_tmp = m_q.pop_front();
                    m_issued = 1'b0;
                    if (m_tmp.is_data) begin
                        exp_dvalid = 1'b1;
                        if (m_tmp.wen == 4'd0) exp_drdata = mem_rdata;
                    end else begin
                        exp_ivalid = 1'b1;
                        exp_irdata = mem_rdata;
                    end
                end
            end else begin
                if (data_req) begin
                    m_tmp.is_data = 1'b1; m_tmp.addr = data_addr;
                    m_tmp.wen = data_wen; m_tmp.wdata = data_wdata;
                    m_q.push_back(m_tmp);
                end
                if (inst_req) begin
                    m_tmp.is_data = 1'b0; m_tmp.addr = inst_addr;
                    m_tmp.wen = 4'd0; m_tmp.wdata = '0;
                    m_q.push_back(m_tmp);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int          n_iv = 0, n_dv = 0, iv_cyc = 0, dv_cyc = 0;
    logic [31:0] iv_data = '0, dv_data = '0;
    logic        exp_req;

    always @(negedge clk) begin
        exp_req = (m_q.size() != 0) && !m_issued;
        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, m_q.size() != 0});
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_ivalid});
        chk("data_valid", {31'd0, data_valid}, {31'd0, exp_dvalid});
        chk("inst_rdata", inst_rdata, exp_irdata);
        chk("data_rdata", data_rdata, exp_drdata);
        if (exp_req) begin
            chk("mem_addr", mem_addr, m_q[0].addr);
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, m_q[0].is_data && (m_q[0].wen != 4'd0)});
            chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_q[0].is_data ? m_q[0].wen : 4'd0});
            if (m_q[0].is_data && m_q[0].wen != 4'd0) chk("mem_wdata", mem_wdata, m_q[0].wdata);
        end
        if (inst_valid) begin n_iv++; iv_cyc = cyc; iv_data = inst_rdata; end
        if (data_valid) begin n_dv++; dv_cyc = cyc; dv_data = data_rdata; end
    end

    // ---------------- slave with programmable wait states ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } acc_t;

    acc_t        s_log[$];
    acc_t        s_acc;
    logic [31:0] rq[$];
    int          addr_wait = 0, data_wait = 0, s_cnt = 0;
    logic        s_phase = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            s_phase = 1'b0; s_cnt = 0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        end else begin
            s_addr_ok = 1'b0;
            s_data_ok = 1'b0;
            if (!s_phase) begin
                if (mem_req) begin
                    if (s_cnt >= addr_wait) begin
                        s_addr_ok = 1'b1; s_phase = 1'b1; s_cnt = 0;
                        s_acc.addr = mem_addr; s_acc.wr = mem_wr;
                        s_acc.wstrb = mem_wstrb; s_acc.wdata = mem_wdata;
                        s_log.push_back(s_acc);
                    end else s_cnt++;
                end
            end else begin
                if (s_cnt >= data_wait) begin
                    s_data_ok = 1'b1;
                    s_rdata = (rq.size() != 0) ? rq.pop_front() : 32'hDEAD_BEEF;
                    s_phase = 1'b0; s_cnt = 0;
                end else s_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                         output int c);
        @(negedge clk);
        inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = wen; data_addr = da; data_wdata = wd;
        c = cyc;
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic wait_pulses(input int ti, input int td);
        int k;
        k = 0;
        while ((n_iv < ti || n_dv < td) && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (n_iv < ti || n_dv < td) chk("completion_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int c, iv0, dv0;

    initial begin
        idle(3);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_valids", {30'd0, inst_valid, data_valid}, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        @(posedge clk); #2 resetn = 1'b1;
        idle(2);

        // single fetch, zero-wait slave
        rq.push_back(32'h2408_0001);
        iv0 = n_iv;
        issue(1'b1, 32'hBFC0_0000, 1'b0, 4'd0, 32'd0, 32'd0, c);
        chk("fetch_cyc1_req", {31'd0, mem_req}, 32'd1);
        chk("fetch_cyc1_addr", mem_addr, 32'hBFC0_0000);
        wait_pulses(iv0 + 1, 0);
        chk("fetch_latency", iv_cyc - c, 32'd3);
        chk("fetch_rdata", iv_data, 32'h2408_0001);
        idle(4);
        chk("fetch_one_pulse", n_iv - iv0, 32'd1);

        // simultaneous data read and fetch
        s_log.delete();
        rq.push_back(32'h1234_5678);
        rq.push_back(32'h0000_000C);
        iv0 = n_iv; dv0 = n_dv;
        issue(1'b1, 32'hBFC0_0004, 1'b1, 4'd0, 32'h8000_0010, 32'd0, c);
        wait_pulses(iv0 + 1, dv0 + 1);
        chk("sim_first_addr", s_log[0].addr, 32'h8000_0010);
        chk("sim_second_addr", s_log[1].addr, 32'hBFC0_0004);
        chk("sim_data_latency", dv_cyc - c, 32'd3);
        chk("sim_inst_after_data", iv_cyc - dv_cyc, 32'd2);
        chk("sim_data_rdata", dv_data, 32'h1234_5678);
        chk("sim_inst_rdata", iv_data, 32'h0000_000C);

        // store: data_rdata must keep the previous load result
        s_log.delete();
        dv0 = n_dv;
        issue(1'b0, 32'd0, 1'b1, 4'b0011, 32'h8000_0020, 32'hAABB_CCDD, c);
        wait_pulses(0, dv0 + 1);
        chk("store_mem_wr", {31'd0, s_log[0].wr}, 32'd1);
        chk("store_wstrb", {28'd0, s_log[0].wstrb}, 32'h3);
        chk("store_wdata", s_log[0].wdata, 32'hAABB_CCDD);
        chk("store_addr", s_log[0].addr, 32'h8000_0020);
        chk("store_rdata_kept", data_rdata, 32'h1234_5678);
        chk("store_pulse", n_dv - dv0, 32'd1);

        // slave backpressure; a fetch raised during the stall must be dropped
        s_log.delete();
        addr_wait = 4; data_wait = 3;
        rq.push_back(32'h1111_2222);
        iv0 = n_iv; dv0 = n_dv;
        issue(1'b0, 32'd0, 1'b1, 4'd0, 32'h8000_0040, 32'd0, c);
        @(negedge clk); inst_req = 1'b1; inst_addr = 32'h0000_0F00;
        idle(3);
        inst_req = 1'b0;
        wait_pulses(0, dv0 + 1);
        chk("bp_latency", dv_cyc - c, 32'd10);
        chk("bp_rdata", dv_data, 32'h1111_2222);
        idle(6);
        chk("bp_no_fetch_captured", n_iv - iv0, 32'd0);
        chk("bp_single_access", s_log.size(), 32'd1);

        // spurious handshakes: addr_ok while idle, data_ok during ADDR
        addr_wait = 3; data_wait = 0;
        f_addr_ok = 1'b1;
        idle(2);
        f_addr_ok = 1'b0;
        rq.push_back(32'h55AA_55AA);
        iv0 = n_iv;
        issue(1'b1, 32'h0000_1000, 1'b0, 4'd0, 32'd0, 32'd0, c);
        f_data_ok = 1'b1;
        idle(2);
        f_data_ok = 1'b0;
        chk("spur_no_pulse", n_iv - iv0, 32'd0);
        wait_pulses(iv0 + 1, 0);
        chk("spur_latency", iv_cyc - c, 32'd6);
        chk("spur_rdata", iv_data, 32'h55AA_55AA);

        // reset while the fetch sits in WAIT
        addr_wait = 0; data_wait = 20;
        rq.push_back(32'h9999_9999);
        iv0 = n_iv;
        issue(1'b1, 32'hBFC0_0000, 1'b0, 4'd0, 32'd0, 32'd0, c);
        idle(2);
        chk("rst_pre_stall", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk); #2 resetn = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
        idle(2);
        rq.delete();
        data_wait = 0;
        @(posedge clk); #2 resetn = 1'b1;
        idle(3);
        chk("rst_no_valid", n_iv - iv0, 32'd0);
        rq.push_back(32'hCAFE_F00D);
        issue(1'b1, 32'hBFC0_0000, 1'b0, 4'd0, 32'd0, 32'd0, c);
        wait_pulses(iv0 + 1, 0);
        chk("rst_fresh_latency", iv_cyc - c, 32'd3);
        chk("rst_fresh_rdata", iv_data, 32'hCAFE_F00D);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
